// File: rtl/muldiv_unit_pkg.sv
// Shared types for the iterative multiply/divide unit: opcode encoding, FSM states and
// operand signedness helpers.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    F3Mul    = 3'b000,
    F3Mulh   = 3'b001,
    F3Mulhsu = 3'b010,
    F3Mulhu  = 3'b011,
    F3Div    = 3'b100,
    F3Divu   = 3'b101,
    F3Rem    = 3'b110,
    F3Remu   = 3'b111
  } muldiv_funct3_t;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } muldiv_state_t;

  // Edges from the start-sampling edge to the edge after which done is visible, inclusive.
  function automatic int unsigned muldiv_lat(int unsigned xlen);
    return xlen + 2;
  endfunction

  function automatic logic rs1_signed(muldiv_funct3_t f);
    return f inside {F3Mulh, F3Mulhsu, F3Div, F3Rem};
  endfunction

  function automatic logic rs2_signed(muldiv_funct3_t f);
    return f inside {F3Mulh, F3Div, F3Rem};
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Accumulator/counter datapath: one radix-2 shift-add multiply or restoring-divide step per
// cycle on unsigned operand magnitudes.
module muldiv_iter_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              is_div_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic              last_o
);

  localparam int unsigned CntW = $clog2(XLEN);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              div_q, div_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [XLEN-1:0]   hi, lo;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     trial;
  logic [2*XLEN-1:0] mul_next, div_next;

  assign hi = acc_q[2*XLEN-1:XLEN];
  assign lo = acc_q[XLEN-1:0];

  // Multiply: {hi, lo} = {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, lo[XLEN-1:1]};

  // Divide: {hi, lo} = {partial remainder, dividend bits shifting into quotient}.
  assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
  assign trial    = rem_sh - {1'b0, opnd_q};
  assign div_next = trial[XLEN] ? {rem_sh[XLEN-1:0], lo[XLEN-2:0], 1'b0}
                                : {trial[XLEN-1:0], lo[XLEN-2:0], 1'b1};

  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      acc_d  = is_div_i ? {{XLEN{1'b0}}, a_i} : {{XLEN{1'b0}}, b_i};
      opnd_d = is_div_i ? b_i : a_i;
      div_d  = is_div_i;
      cnt_d  = CntW'(XLEN - 1);
    end else if (step_i) begin
      acc_d = div_q ? div_next : mul_next;
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
    end
  end

  assign acc_o  = acc_q;
  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: FSM, sign handling, special cases.
// Optional last-divide result cache enabled by defining MULDIV_CACHE_EN.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t  state_q, state_d;
  muldiv_funct3_t op_q, op_d;
  logic           sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [XLEN-1:0] result_q, result_d;

  muldiv_funct3_t  f3_in;
  logic            sa, sb, is_div, div_zero, ovf;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            core_load, core_step, core_last;
  logic [2*XLEN-1:0] acc, prod_n;
  logic [XLEN-1:0] quo_fix, rem_fix, fix_val;
  logic            cache_hit;
  logic [XLEN-1:0] cache_val;

  assign f3_in    = muldiv_funct3_t'(funct3_i);
  assign sa       = rs1_signed(f3_in) & rs1_data_i[XLEN-1];
  assign sb       = rs2_signed(f3_in) & rs2_data_i[XLEN-1];
  assign abs_a    = sa ? -rs1_data_i : rs1_data_i;
  assign abs_b    = sb ? -rs2_data_i : rs2_data_i;
  assign is_div   = f3_in[2];
  assign div_zero = is_div && (rs2_data_i == '0);
  assign ovf      = (f3_in == F3Div || f3_in == F3Rem) && (rs1_data_i == MinVal)
                    && (rs2_data_i == '1);

  muldiv_iter_core #(
    .XLEN(XLEN)
  ) u_core (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (core_load),
    .step_i  (core_step),
    .is_div_i(is_div),
    .a_i     (abs_a),
    .b_i     (abs_b),
    .acc_o   (acc),
    .last_o  (core_last)
  );

  // Quotient/product take sA^sB, remainder takes sA.
  assign prod_n  = (sign_a_q ^ sign_b_q) ? -acc : acc;
  assign quo_fix = (sign_a_q ^ sign_b_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem_fix = sign_a_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_comb begin
    fix_val = '0;
    unique case (op_q)
      F3Mul:                     fix_val = prod_n[XLEN-1:0];
      F3Mulh, F3Mulhsu, F3Mulhu: fix_val = prod_n[2*XLEN-1:XLEN];
      F3Div, F3Divu:             fix_val = quo_fix;
      F3Rem, F3Remu:             fix_val = rem_fix;
      default:                   fix_val = '0;
    endcase
  end

`ifdef MULDIV_CACHE_EN
  logic            cache_vld_q, cache_signed_q;
  logic [XLEN-1:0] cache_a_q, cache_b_q, cache_quo_q, cache_rem_q;
  logic [XLEN-1:0] rs1_q, rs2_q;

  assign cache_hit = is_div && cache_vld_q && (cache_a_q == rs1_data_i)
                     && (cache_b_q == rs2_data_i) && (cache_signed_q == !f3_in[0]);
  assign cache_val = f3_in[1] ? cache_rem_q : cache_quo_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cache_vld_q    <= 1'b0;
      cache_signed_q <= 1'b0;
      cache_a_q      <= '0;
      cache_b_q      <= '0;
      cache_quo_q    <= '0;
      cache_rem_q    <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
    end else begin
      if (core_load) begin
        rs1_q <= rs1_data_i;
        rs2_q <= rs2_data_i;
      end
      if (flush_i && state_q != StIdle && op_q[2]) begin
        cache_vld_q <= 1'b0;
      end else if (state_q == StFix && op_q[2]) begin
        cache_vld_q    <= 1'b1;
        cache_signed_q <= !op_q[0];
        cache_a_q      <= rs1_q;
        cache_b_q      <= rs2_q;
        cache_quo_q    <= quo_fix;
        cache_rem_q    <= rem_fix;
      end
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_val = '0;
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    result_d  = result_q;
    core_load = 1'b0;
    core_step = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i && !flush_i) begin
          op_d     = f3_in;
          sign_a_d = sa;
          sign_b_d = sb;
          if (div_zero) begin
            result_d = f3_in[1] ? rs1_data_i : '1;
            state_d  = StDone;
          end else if (ovf) begin
            result_d = f3_in[1] ? '0 : rs1_data_i;
            state_d  = StDone;
          end else if (cache_hit) begin
            result_d = cache_val;
            state_d  = StDone;
          end else begin
            core_load = 1'b1;
            state_d   = StCalc;
          end
        end
      end
      StCalc: begin
        core_step = 1'b1;
        if (core_last) state_d = StFix;
      end
      StFix: begin
        result_d = fix_val;
        state_d  = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Abort leaves the previously returned result visible.
    if (flush_i && state_q != StIdle) begin
      state_d   = StIdle;
      result_d  = result_q;
      core_step = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      op_q     <= F3Mul;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      result_q <= result_d;
    end
  end

  assign ready_o  = (state_q == StIdle);
  assign done_o   = (state_q == StDone);
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit (XLEN=32 table plus an XLEN=64 instance).
module tb_muldiv_unit;

`ifdef MULDIV_CACHE_EN
  localparam int CacheLat = 1;
`else
  localparam int CacheLat = 34;
`endif

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, flush;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2, result;
  logic        ready, done;

  logic        start64;
  logic [2:0]  funct3_64;
  logic [63:0] rs1_64, rs2_64, result64;
  logic        ready64, done64;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start),
    .funct3_i  (funct3),
    .rs1_data_i(rs1),
    .rs2_data_i(rs2),
    .flush_i   (flush),
    .ready_o   (ready),
    .done_o    (done),
    .result_o  (result)
  );

  muldiv_unit #(.XLEN(64)) dut64 (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start64),
    .funct3_i  (funct3_64),
    .rs1_data_i(rs1_64),
    .rs2_data_i(rs2_64),
    .flush_i   (1'b0),
    .ready_o   (ready64),
    .done_o    (done64),
    .result_o  (result64)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one op; hold keeps start high (with junk operands) for that many extra edges.
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input int hold);
    int  cycles;
    bit  got, rdy_bad;
    @(negedge clk);
    check({name, " ready before"}, 64'(ready), 64'd1);
    start = 1'b1; funct3 = f3; rs1 = a; rs2 = b;
    cycles = 0; got = 0; rdy_bad = 0;
    while (!got && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles > hold) start = 1'b0;
      else begin
        rs1 = $urandom; rs2 = $urandom; funct3 = 3'($urandom);
      end
      if (done) got = 1;
      else if (ready) rdy_bad = 1;
    end
    start = 1'b0;
    check({name, " result"}, 64'(result), 64'(exp));
    check({name, " latency"}, 64'(cycles), 64'(lat));
    check({name, " ready low while busy"}, 64'(rdy_bad), 64'd0);
    @(posedge clk); #1;
    check({name, " done pulse / ready after"}, {62'd0, done, ready}, 64'd1);
  endtask

  vec_t vecs[18];

  initial begin
    int dcount;
    int cycles;
    vecs[0]  = '{3'b000, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34};
    vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34};
    vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 34};
    vecs[4]  = '{3'b000, 32'hFFFF,     32'hFFFF,     32'hFFFE0001, 34};
    vecs[5]  = '{3'b011, 32'h10000,    32'h10000,    32'h1,        34};
    vecs[6]  = '{3'b100, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 34};
    vecs[7]  = '{3'b110, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, CacheLat};
    vecs[8]  = '{3'b101, 32'h5,        32'h0,        32'hFFFFFFFF, 1};
    vecs[9]  = '{3'b111, 32'h5,        32'h0,        32'h5,        1};
    vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1};
    vecs[12] = '{3'b100, 32'h14,       32'hFFFFFFFD, 32'hFFFFFFFA, 34};
    vecs[13] = '{3'b110, 32'h14,       32'hFFFFFFFD, 32'h2,        CacheLat};
    vecs[14] = '{3'b110, 32'hFFFFFFEC, 32'h3,        32'hFFFFFFFE, 34};
    vecs[15] = '{3'b101, 32'hFFFFFFEC, 32'h3,        32'h5555554E, 34};
    vecs[16] = '{3'b101, 32'h64,       32'h7,        32'hE,        34};
    vecs[17] = '{3'b111, 32'h64,       32'h7,        32'h2,        CacheLat};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = 3'b000; rs1 = '0; rs2 = '0;
    start64 = 1'b0; funct3_64 = 3'b000; rs1_64 = '0; rs2_64 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset state", {result, 30'd0, done, ready}, {32'd0, 30'd0, 1'b0, 1'b1});
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp,
             vecs[i].lat, 0);
    end

    // Flush at cycle 10 of a divide.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b100; rs1 = 32'h3E8; rs2 = 32'h9;
    @(posedge clk); #1; start = 1'b0;
    dcount = 0;
    repeat (9) begin @(posedge clk); #1; if (done) dcount++; end
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush ready/done", {62'd0, done, ready}, 64'd1);
    check("flush keeps result", 64'(result), 64'h2);
    repeat (40) begin @(posedge clk); #1; if (done) dcount++; end
    check("flush no done", 64'(dcount), 64'd0);

    // start held while busy is ignored.
    run_op("mul 3x4 held start", 3'b000, 32'd3, 32'd4, 32'd12, 34, 3);

    // flush together with start in IDLE drops the start.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'b000; rs1 = 32'd5; rs2 = 32'd5;
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    check("flush+start ready", 64'(ready), 64'd1);
    dcount = 0;
    repeat (40) begin @(posedge clk); #1; if (done) dcount++; end
    check("flush+start no done", 64'(dcount), 64'd0);
    check("flush+start result", 64'(result), 64'd12);

    // Reset mid-CALC.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; rs1 = 32'd9; rs2 = 32'd9;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check("reset mid-calc", {result, 30'd0, done, ready}, {32'd0, 30'd0, 1'b0, 1'b1});
    @(negedge clk); rst_n = 1'b1;
    dcount = 0;
    repeat (40) begin @(posedge clk); #1; if (done) dcount++; end
    check("reset mid-calc no done", 64'(dcount), 64'd0);

    // XLEN=64: divu 2^40 / 3.
    @(negedge clk);
    start64 = 1'b1; funct3_64 = 3'b101; rs1_64 = 64'h100_0000_0000; rs2_64 = 64'd3;
    cycles = 0;
    do begin
      @(posedge clk); #1; start64 = 1'b0; cycles++;
    end while (!done64 && cycles < 300);
    check("xlen64 divu result", result64, 64'h55_5555_5555);
    check("xlen64 divu latency", 64'(cycles), 64'd66);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
